xdma_stream_to_axi_write: RTL and testbench

//  Source-side AXI write burst generator for the XDMA datapath. Takes a write descriptor (dst addr, beat count)
//  and a stream of data beats. Emits one AXI4 INCR write burst (AW + W) per descriptor and retires B responses.
//  Its AXI master port drives the remote cluster's AXI-to-reqrsp write converter.
//  It never issues AR and ignores R.

---
 rtl/xdma_axi_if.sv | 46 ++++
 rtl/xdma_stream_to_axi_write.sv | 214 +++++++++++++++++++++
 tb/tb_xdma_stream_to_axi_write.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xdma_axi_if.sv
// AXI4 write-side bundle between the XDMA burst generator (master) and the remote
// write converter (slave); read channel reduced to its two tie-off controls.
interface xdma_axi_if #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned IdWidth   = 3
);
    logic                     aw_valid;
    logic                     aw_ready;
    logic [AddrWidth-1:0]     aw_addr;
    logic [7:0]               aw_len;
    logic [2:0]               aw_size;
    logic [1:0]               aw_burst;
    logic [IdWidth-1:0]       aw_id;
    logic [3:0]               aw_cache;
    logic [2:0]               aw_prot;
    logic [3:0]               aw_qos;
    logic                     aw_lock;
    logic [5:0]               aw_atop;
    logic [3:0]               aw_region;
    logic                     aw_user;
    logic                     w_valid;
    logic                     w_ready;
    logic [DataWidth-1:0]     w_data;
    logic [DataWidth/8-1:0]   w_strb;
    logic                     w_last;
    logic                     b_valid;
    logic                     b_ready;
    logic [1:0]               b_resp;
    logic                     ar_valid;
    logic                     r_ready;

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_cache, aw_prot,
               aw_qos, aw_lock, aw_atop, aw_region, aw_user,
               w_valid, w_data, w_strb, w_last, b_ready, ar_valid, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_cache, aw_prot,
               aw_qos, aw_lock, aw_atop, aw_region, aw_user,
               w_valid, w_data, w_strb, w_last, b_ready, ar_valid, r_ready,
        output aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/xdma_stream_to_axi_write.sv
// XDMA source-side write burst generator: one AXI4 INCR burst (AW + streamed W) per
// descriptor, with B retirement, an outstanding-burst limit and a sticky error flag.
module xdma_stream_to_axi_write_chk #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned BeatBytes = 64,
    parameter int unsigned OutW      = 3
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 desc_hs_i,
    input logic [AddrWidth-1:0] desc_addr_i,
    input logic [7:0]           desc_len_i,
    input logic                 b_hs_i,
    input logic [OutW-1:0]      outstanding_i
);
    a_desc_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        desc_hs_i |-> ((desc_addr_i % AddrWidth'(BeatBytes)) == '0))
        else $error("descriptor address not beat aligned");

    a_desc_4k: assert property (@(posedge clk_i) disable iff (!rst_ni)
        desc_hs_i |-> ((32'(desc_addr_i[11:0]) + (32'(desc_len_i) + 32'd1) * BeatBytes) <= 32'd4096))
        else $error("descriptor burst crosses a 4 KiB boundary");

    a_b_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_hs_i |-> (outstanding_i != '0))
        else $error("B response received with no burst outstanding");
endmodule

module xdma_stream_to_axi_write #(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 512,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned AwId           = 0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     desc_valid_i,
    output logic                                     desc_ready_o,
    input  logic [AddrWidth-1:0]                     desc_addr_i,
    input  logic [7:0]                               desc_len_i,
    input  logic                                     data_valid_i,
    output logic                                     data_ready_o,
    input  logic [DataWidth-1:0]                     data_i,
    input  logic [DataWidth/8-1:0]                   strb_i,
    xdma_axi_if.master                               axi_m,
    output logic                                     busy_o,
    output logic                                     err_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]      outstanding_o
);
    localparam int unsigned BeatBytes = DataWidth / 8;
    localparam int unsigned OutW      = $clog2(MaxOutstanding + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             beat_cnt_q, beat_cnt_d;
    logic                   aw_pend_q, aw_pend_d;
    logic                   w_done_q, w_done_d;
    logic [OutW-1:0]        outstanding_q, outstanding_d;
    logic                   err_q, err_d;
    logic                   active_q;

    logic desc_ready_s, desc_hs_s;
    logic aw_valid_s, aw_hs_s;
    logic w_active_s, w_valid_s, w_hs_s, w_last_s;
    logic b_raw_hs_s, b_hs_s;

    // Handshake decode; valids depend only on state and upstream valid, never on ready.
    always_comb begin
        desc_ready_s = active_q && (state_q == ST_IDLE) && (outstanding_q < OutW'(MaxOutstanding));
        desc_hs_s    = desc_valid_i && desc_ready_s;
        aw_valid_s   = (state_q == ST_BURST) && aw_pend_q;
        aw_hs_s      = aw_valid_s && axi_m.aw_ready;
        w_active_s   = (state_q == ST_BURST) && !w_done_q;
        w_valid_s    = w_active_s && data_valid_i;
        w_hs_s       = w_valid_s && axi_m.w_ready;
        w_last_s     = w_active_s && (beat_cnt_q == 8'd0);
        b_raw_hs_s   = axi_m.b_valid && active_q;
        b_hs_s       = b_raw_hs_s && (outstanding_q != '0);
    end

    // Next-state logic for the burst FSM, outstanding counter and sticky error.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        aw_pend_d     = aw_pend_q;
        w_done_d      = w_done_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (desc_hs_s) begin
                    addr_d     = desc_addr_i;
                    len_d      = desc_len_i;
                    beat_cnt_d = desc_len_i;
                    aw_pend_d  = 1'b1;
                    w_done_d   = 1'b0;
                    state_d    = ST_BURST;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (aw_hs_s) begin
                    aw_pend_d = 1'b0;
                end else begin
                    aw_pend_d = aw_pend_q;
                end
                if (w_hs_s) begin
                    if (w_last_s) begin
                        w_done_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end else begin
                    w_done_d = w_done_q;
                end
                // AW and the final W may both complete in this same cycle.
                if (!aw_pend_d && w_done_d) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case ({aw_hs_s, b_hs_s})
            2'b10:   outstanding_d = outstanding_q + OutW'(1);
            2'b01:   outstanding_d = outstanding_q - OutW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (b_hs_s && axi_m.b_resp[1]) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset abandons any burst and all outstanding responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            len_q         <= 8'd0;
            beat_cnt_q    <= 8'd0;
            aw_pend_q     <= 1'b0;
            w_done_q      <= 1'b0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            aw_pend_q     <= aw_pend_d;
            w_done_q      <= w_done_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            active_q      <= 1'b1;
        end
    end

    assign desc_ready_o    = desc_ready_s;
    assign data_ready_o    = w_active_s && axi_m.w_ready;
    assign busy_o          = (state_q != ST_IDLE) || (outstanding_q != '0);
    assign err_o           = err_q;
    assign outstanding_o   = outstanding_q;

    assign axi_m.aw_valid  = aw_valid_s;
    assign axi_m.aw_addr   = aw_valid_s ? addr_q : '0;
    assign axi_m.aw_len    = aw_valid_s ? len_q : 8'd0;
    assign axi_m.aw_size   = aw_valid_s ? 3'($clog2(BeatBytes)) : 3'd0;
    assign axi_m.aw_burst  = aw_valid_s ? 2'b01 : 2'b00;
    assign axi_m.aw_id     = aw_valid_s ? IdWidth'(AwId) : '0;
    assign axi_m.aw_cache  = 4'd0;
    assign axi_m.aw_prot   = 3'd0;
    assign axi_m.aw_qos    = 4'd0;
    assign axi_m.aw_lock   = 1'b0;
    assign axi_m.aw_atop   = 6'd0;
    assign axi_m.aw_region = 4'd0;
    assign axi_m.aw_user   = 1'b0;
    assign axi_m.w_valid   = w_valid_s;
    assign axi_m.w_data    = w_active_s ? data_i : '0;
    assign axi_m.w_strb    = w_active_s ? strb_i : '0;
    assign axi_m.w_last    = w_last_s;
    assign axi_m.b_ready   = active_q;
    assign axi_m.ar_valid  = 1'b0;
    assign axi_m.r_ready   = 1'b0;

    xdma_stream_to_axi_write_chk #(
        .AddrWidth (AddrWidth),
        .BeatBytes (BeatBytes),
        .OutW      (OutW)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .desc_hs_i     (desc_hs_s),
        .desc_addr_i   (desc_addr_i),
        .desc_len_i    (desc_len_i),
        .b_hs_i        (b_raw_hs_s),
        .outstanding_i (outstanding_q)
    );
endmodule

// File: tb/tb_xdma_stream_to_axi_write.sv
// Self-checking bench: descriptor table plus corner-case sequences; AW and W beats
// are scoreboarded against expectations queued when the stimulus is driven.
module tb_xdma_stream_to_axi_write;
    localparam int AW = 48;
    localparam int DW = 512;
    localparam int IW = 3;
    localparam int SW = DW / 8;
    localparam int OW = 3;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b1;
    logic           desc_valid = 1'b0;
    logic           desc_ready;
    logic [AW-1:0]  desc_addr = '0;
    logic [7:0]     desc_len = 8'd0;
    logic           data_valid = 1'b0;
    logic           data_ready;
    logic [DW-1:0]  data = '0;
    logic [SW-1:0]  strb = '0;
    logic           busy;
    logic           err;
    logic [OW-1:0]  outstanding;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xdma_axi_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) axi ();

    xdma_stream_to_axi_write dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .desc_valid_i  (desc_valid),
        .desc_ready_o  (desc_ready),
        .desc_addr_i   (desc_addr),
        .desc_len_i    (desc_len),
        .data_valid_i  (data_valid),
        .data_ready_o  (data_ready),
        .data_i        (data),
        .strb_i        (strb),
        .axi_m         (axi.master),
        .busy_o        (busy),
        .err_o         (err),
        .outstanding_o (outstanding)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } w_exp_t;
    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        int            aw_delay;
        logic [1:0]    resp;
        logic          exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int s);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = (32'(s) * 32'h9E37_79B1) ^ 32'(k);
        return d;
    endfunction

    function automatic logic [SW-1:0] mk_strb(input int s);
        logic [SW-1:0] r;
        for (int k = 0; k < SW / 8; k++) r[k*8 +: 8] = 8'(s * 7 + k) ^ 8'hC3;
        return r;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, handshakes complete on the next rise.
    logic          aw_stall_prev = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0]    prev_len = 8'd0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            aw_stall_prev = 1'b0;
        end else begin
            if (aw_stall_prev) begin
                chk("aw_hold_valid", 64'(axi.aw_valid), 64'd1);
                chk("aw_hold_addr", 64'(axi.aw_addr), 64'(prev_addr));
                chk("aw_hold_len", 64'(axi.aw_len), 64'(prev_len));
            end
            if (axi.aw_valid && axi.aw_ready) begin
                if (exp_aw.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL aw_unexpected actual=%0h required=none", axi.aw_addr);
                end else begin
                    aw_exp_t e;
                    e = exp_aw.pop_front();
                    chk("aw_addr", 64'(axi.aw_addr), 64'(e.addr));
                    chk("aw_len", 64'(axi.aw_len), 64'(e.len));
                    chk("aw_size", 64'(axi.aw_size), 64'd6);
                    chk("aw_burst", 64'(axi.aw_burst), 64'd1);
                    chk("aw_id", 64'(axi.aw_id), 64'd0);
                end
            end
            if (axi.w_valid && axi.w_ready) begin
                if (exp_w.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w_unexpected actual=%0h required=none", axi.w_data[31:0]);
                end else begin
                    w_exp_t e;
                    e = exp_w.pop_front();
                    checks++;
                    if (axi.w_data !== e.data) begin
                        errors++;
                        $display("FAIL w_data actual=%0h required=%0h", axi.w_data[63:0], e.data[63:0]);
                    end
                    chk("w_strb", 64'(axi.w_strb), 64'(e.strb));
                    chk("w_last", 64'(axi.w_last), 64'(e.last));
                    chk("w_data_ready", 64'(data_ready), 64'd1);
                end
            end
            aw_stall_prev = axi.aw_valid && !axi.aw_ready;
            prev_addr     = axi.aw_addr;
            prev_len      = axi.aw_len;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [AW-1:0] a, input logic [7:0] l);
        logic ok;
        ok = 1'b0;
        exp_aw.push_back('{addr: a, len: l});
        desc_valid = 1'b1; desc_addr = a; desc_len = l;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (desc_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL desc_timeout actual=0 required=1");
        end
        sync();
        desc_valid = 1'b0;
    endtask

    task automatic send_beats(input int first, input int count, input int total, input int base);
        logic ok;
        for (int i = first; i < first + count; i++) begin
            data_valid = 1'b1;
            data = mk_data(base + i);
            strb = mk_strb(base + i);
            exp_w.push_back('{data: data, strb: strb, last: (i == total - 1)});
            ok = 1'b0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (data_ready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL data_timeout actual=0 required=1");
            end
            sync();
        end
        data_valid = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] r);
        logic ok;
        sync();
        axi.b_valid = 1'b1; axi.b_resp = r;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (axi.b_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL b_timeout actual=0 required=1");
        end
        sync();
        axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    endtask

    task automatic wait_aw_done();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!axi.aw_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL aw_timeout actual=1 required=0");
        end
    endtask

    task automatic run_burst(input logic [AW-1:0] a, input logic [7:0] l, input int aw_delay, input int base);
        sync();
        axi.aw_ready = (aw_delay == 0);
        axi.w_ready  = 1'b1;
        fork
            send_desc(a, l);
            send_beats(0, int'(l) + 1, int'(l) + 1, base);
            begin
                if (aw_delay > 0) begin
                    repeat (aw_delay) @(posedge clk);
                    #1;
                    axi.aw_ready = 1'b1;
                end
            end
        join
        wait_aw_done();
    endtask

    initial begin
        logic err_model;
        axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b0; axi.b_resp = 2'b00;

        vecs[0] = '{addr: 48'h0000_0000_1000, len: 8'd0,  aw_delay: 0, resp: 2'b00, exp_err: 1'b0};
        vecs[1] = '{addr: 48'h0000_0000_2040, len: 8'd3,  aw_delay: 0, resp: 2'b00, exp_err: 1'b0};
        vecs[2] = '{addr: 48'h0000_0000_3000, len: 8'd7,  aw_delay: 5, resp: 2'b00, exp_err: 1'b0};
        vecs[3] = '{addr: 48'h0000_0000_4FC0, len: 8'd0,  aw_delay: 2, resp: 2'b00, exp_err: 1'b0};
        vecs[4] = '{addr: 48'h0000_0000_5000, len: 8'd63, aw_delay: 0, resp: 2'b00, exp_err: 1'b0};
        vecs[5] = '{addr: 48'hABCD_0000_0080, len: 8'd1,  aw_delay: 1, resp: 2'b00, exp_err: 1'b0};
        vecs[6] = '{addr: 48'h0000_0000_7000, len: 8'd2,  aw_delay: 0, resp: 2'b01, exp_err: 1'b0};

        // Reset with descriptor and data already presented
        desc_valid = 1'b1; data_valid = 1'b1; data = mk_data(1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_aw_valid", 64'(axi.aw_valid), 64'd0);
        chk("rst_w_valid", 64'(axi.w_valid), 64'd0);
        chk("rst_b_ready", 64'(axi.b_ready), 64'd0);
        chk("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
        chk("rst_desc_ready", 64'(desc_ready), 64'd0);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        desc_valid = 1'b0; data_valid = 1'b0;
        rst_ni = 1'b1;
        sync();

        // Table-driven single bursts
        err_model = 1'b0;
        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].aw_delay, 1000 * (v + 1));
            @(negedge clk);
            chk("vec_out_mid", 64'(outstanding), 64'd1);
            chk("vec_busy_mid", 64'(busy), 64'd1);
            chk("vec_desc_ready", 64'(desc_ready), 64'd1);
            send_b(vecs[v].resp);
            err_model = err_model | vecs[v].resp[1];
            @(negedge clk);
            chk("vec_out_end", 64'(outstanding), 64'd0);
            chk("vec_busy_end", 64'(busy), 64'd0);
            chk("vec_err", 64'(err), 64'(vecs[v].exp_err));
            chk("vec_err_model", 64'(err), 64'(err_model));
        end

        // AW stalled 3 cycles by a peer that withholds W until AW is accepted
        sync();
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
        fork
            send_desc(48'h0000_0000_8000, 8'd3);
            send_beats(0, 4, 4, 100);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("t2_data_stall", 64'(data_ready), 64'd0);
                    if (i > 0) chk("t2_aw_valid", 64'(axi.aw_valid), 64'd1);
                end
                sync();
                axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
            end
        join
        wait_aw_done();
        @(negedge clk);
        chk("t2_out", 64'(outstanding), 64'd1);
        send_b(2'b00);
        @(negedge clk);
        chk("t2_out_end", 64'(outstanding), 64'd0);

        // Outstanding limit with B withheld
        for (int i = 0; i < 4; i++) run_burst(48'h0000_0000_A000 + 48'(i) * 48'h1000, 8'd0, 0, 200 + i);
        @(negedge clk);
        chk("t3_out_full", 64'(outstanding), 64'd4);
        chk("t3_desc_blocked", 64'(desc_ready), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        sync();
        fork
            send_desc(48'h0000_0000_F000, 8'd0);
            send_beats(0, 1, 1, 300);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("t3_fifth_blocked", 64'(desc_ready), 64'd0);
                    chk("t3_out_cap", 64'(outstanding), 64'd4);
                end
                send_b(2'b00);
            end
        join
        wait_aw_done();
        @(negedge clk);
        chk("t3_out_after", 64'(outstanding), 64'd4);

        // Same-cycle AW handshake and B for an earlier burst
        for (int i = 0; i < 3; i++) send_b(2'b00);
        @(negedge clk);
        chk("t4_out_pre", 64'(outstanding), 64'd1);
        sync();
        axi.aw_ready = 1'b0;
        fork
            send_desc(48'h0000_0000_E000, 8'd1);
            send_beats(0, 2, 2, 400);
        join
        @(negedge clk);
        chk("t4_aw_pending", 64'(axi.aw_valid), 64'd1);
        sync();
        axi.aw_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b00;
        @(negedge clk);
        chk("t4_b_ready", 64'(axi.b_ready), 64'd1);
        chk("t4_aw_valid", 64'(axi.aw_valid), 64'd1);
        sync();
        axi.b_valid = 1'b0;
        @(negedge clk);
        chk("t4_out_same", 64'(outstanding), 64'd1);
        chk("t4_busy", 64'(busy), 64'd1);
        send_b(2'b00);
        @(negedge clk);
        chk("t4_out_end", 64'(outstanding), 64'd0);

        // SLVERR on the second of three bursts
        for (int i = 0; i < 3; i++) begin
            run_burst(48'h0000_0001_1000 + 48'(i) * 48'h100, 8'd1, 0, 500 + 10 * i);
            sync();
            axi.b_valid = 1'b1; axi.b_resp = (i == 1) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("t5_err_before", 64'(err), 64'(i == 2));
            sync();
            axi.b_valid = 1'b0; axi.b_resp = 2'b00;
            @(negedge clk);
            chk("t5_err_after", 64'(err), 64'(i >= 1));
            chk("t5_out", 64'(outstanding), 64'd0);
        end

        // Asynchronous reset during beat 2 of 8
        sync();
        axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
        fork
            send_desc(48'h0000_0003_0000, 8'd7);
            send_beats(0, 1, 8, 600);
        join
        data_valid = 1'b1; data = mk_data(601); strb = mk_strb(601);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_aw_valid", 64'(axi.aw_valid), 64'd0);
        chk("t6_w_valid", 64'(axi.w_valid), 64'd0);
        chk("t6_w_last", 64'(axi.w_last), 64'd0);
        chk("t6_data_ready", 64'(data_ready), 64'd0);
        chk("t6_desc_ready", 64'(desc_ready), 64'd0);
        chk("t6_b_ready", 64'(axi.b_ready), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        chk("t6_out", 64'(outstanding), 64'd0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        exp_w.delete();
        exp_aw.delete();
        rst_ni = 1'b1;
        run_burst(48'h0000_0004_0000, 8'd3, 0, 700);
        @(negedge clk);
        chk("t6_fresh_out", 64'(outstanding), 64'd1);
        send_b(2'b00);
        @(negedge clk);
        chk("t6_fresh_end", 64'(outstanding), 64'd0);
        chk("t6_fresh_busy", 64'(busy), 64'd0);
        chk("t6_fresh_err", 64'(err), 64'd0);

        chk("sb_aw_empty", 64'(exp_aw.size()), 64'd0);
        chk("sb_w_empty", 64'(exp_w.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
